issue_select_wakeup: RTL and testbench

Select-and-wakeup companion to the issue slots. Each cycle it picks at most one requesting slot and drives that slot's grant. It records the granted uop's destination physical register in a latency delay line, then broadcasts it on wakeup port 0 exactly L cycles after the grant. Wakeup port 1 is an external (memory) wakeup path, retimed through one register.

---
 rtl/issue_pkg.sv | 25 ++
 rtl/issue_rr_arbiter.sv | 49 ++++
 rtl/issue_select_wakeup.sv | 164 ++++++++++++++++
 tb/tb_issue_select_wakeup.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// issue_pkg : shared widths, delay-line entry type and kill helper
// Rev 1.0
// ---------------------------------------------------------------------------
package issue_pkg;

   localparam int PREG_W  = 7;
   localparam int BR_W    = 12;
   localparam int MAX_LAT = 4;
   localparam int LAT_W   = $clog2(MAX_LAT);

   typedef struct packed {
      logic              valid;
      logic [PREG_W-1:0] pdst;
      logic [BR_W-1:0]   br_mask;
   } wakeup_t;

   function automatic logic kill_hit(input logic [BR_W-1:0] mask,
                                     input logic [BR_W-1:0] mispredict);
      return |(mask & mispredict);
   endfunction

endpackage
`default_nettype wire

// File: rtl/issue_rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// issue_rr_arbiter : one-hot grant from an eligible vector
// RR_ARB_EN defined: round-robin from i_ptr; undefined: lowest index wins.
// Rev 1.0
// ---------------------------------------------------------------------------
module issue_rr_arbiter #(
   parameter int N     = 8,
   parameter int PTR_W = 3
) (
   input  logic [N-1:0]     i_eligible,
   input  logic [PTR_W-1:0] i_ptr,
   output logic [N-1:0]     o_grant
);

`ifdef RR_ARB_EN
   always_comb begin
      int   w_idx;
      logic w_found;
      o_grant = '0;
      w_found = 1'b0;
      w_idx   = 0;
      for (int off = 0; off < N; off++) begin
         w_idx = (int'(i_ptr) + off) % N;
         if (!w_found && i_eligible[w_idx]) begin
            o_grant[w_idx] = 1'b1;
            w_found        = 1'b1;
         end
      end
   end
`else
   logic w_unused_ptr;
   assign w_unused_ptr = ^i_ptr;

   always_comb begin
      logic w_found;
      o_grant = '0;
      w_found = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!w_found && i_eligible[i]) begin
            o_grant[i] = 1'b1;
            w_found    = 1'b1;
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: rtl/issue_select_wakeup.sv
`default_nettype none
// ---------------------------------------------------------------------------
// issue_select_wakeup : select one slot per cycle, schedule its wakeup L cycles
// later, retime the external wakeup. RR_ARB_EN selects round-robin arbitration.
// Rev 1.0
// ---------------------------------------------------------------------------
module issue_select_wakeup
   import issue_pkg::*;
#(
   parameter int NUM_SLOTS = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_SLOTS-1:0]          io_request,
   input  logic [NUM_SLOTS*PREG_W-1:0]   io_slot_pdst,
   input  logic [NUM_SLOTS-1:0]          io_slot_ldst_val,
   input  logic [NUM_SLOTS*LAT_W-1:0]    io_slot_lat,
   input  logic [NUM_SLOTS*BR_W-1:0]     io_slot_br_mask,
   input  logic                          io_stall,
   output logic [NUM_SLOTS-1:0]          io_grant,
   output logic                          io_iss_valid,
   output logic [PREG_W-1:0]             io_iss_pdst,
   input  logic [BR_W-1:0]               io_br_mispredict_mask,
   input  logic [BR_W-1:0]               io_br_resolve_mask,
   input  logic                          io_flush,
   input  logic                          io_ext_wakeup_valid,
   input  logic [PREG_W-1:0]             io_ext_wakeup_pdst,
   output logic                          io_wakeup_ports_0_valid,
   output logic [PREG_W-1:0]             io_wakeup_ports_0_bits_pdst,
   output logic                          io_wakeup_ports_1_valid,
   output logic [PREG_W-1:0]             io_wakeup_ports_1_bits_pdst
);

   localparam int PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

   wakeup_t              r_sr     [MAX_LAT];
   wakeup_t              w_sr_nxt [MAX_LAT];
   wakeup_t              w_ins;
   logic [NUM_SLOTS-1:0] w_eligible;
   logic [NUM_SLOTS-1:0] w_coll;
   logic [PTR_W-1:0]     w_ptr;
   logic                 w_g_ldst;
   logic [LAT_W-1:0]     w_g_lat;
   logic [PREG_W-1:0]    w_g_pdst;
   logic [BR_W-1:0]      w_g_br;
   logic                 r_p1_valid;
   logic [PREG_W-1:0]    r_p1_pdst;

   // Entries cleared to all-zero when killed so invalid stages never leak a stale tag.
   function automatic wakeup_t age(input wakeup_t e, input logic [BR_W-1:0] kill,
                                   input logic [BR_W-1:0] res);
      wakeup_t r;
      r = '0;
      if (e.valid && !kill_hit(e.br_mask, kill)) begin
         r.valid   = 1'b1;
         r.pdst    = e.pdst;
         r.br_mask = e.br_mask & ~res;
      end
      return r;
   endfunction

   // A valid sr[L] would shift into sr[L-1] exactly when this slot would write it.
   always_comb begin
      w_coll     = '0;
      w_eligible = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         for (int k = 1; k < MAX_LAT; k++) begin
            if (io_slot_ldst_val[i] && r_sr[k].valid &&
                io_slot_lat[i*LAT_W +: LAT_W] == LAT_W'(k-1))
               w_coll[i] = 1'b1;
         end
         w_eligible[i] = io_request[i] & ~io_stall & ~io_flush & ~w_coll[i];
      end
   end

   issue_rr_arbiter #(
      .N     (NUM_SLOTS),
      .PTR_W (PTR_W)
   ) u_arb (
      .i_eligible (w_eligible),
      .i_ptr      (w_ptr),
      .o_grant    (io_grant)
   );

   always_comb begin
      w_g_ldst = 1'b0;
      w_g_lat  = '0;
      w_g_pdst = '0;
      w_g_br   = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (io_grant[i]) begin
            w_g_ldst = io_slot_ldst_val[i];
            w_g_lat  = io_slot_lat[i*LAT_W +: LAT_W];
            w_g_pdst = io_slot_pdst[i*PREG_W +: PREG_W];
            w_g_br   = io_slot_br_mask[i*BR_W +: BR_W];
         end
      end
   end

   assign io_iss_valid = |io_grant;
   assign io_iss_pdst  = w_g_pdst;

   always_comb begin
      w_ins.valid   = 1'b1;
      w_ins.pdst    = w_g_pdst;
      w_ins.br_mask = w_g_br;
      for (int k = 0; k < MAX_LAT-1; k++)
         w_sr_nxt[k] = age(r_sr[k+1], io_br_mispredict_mask, io_br_resolve_mask);
      w_sr_nxt[MAX_LAT-1] = '0;
      if (io_iss_valid && w_g_ldst)
         w_sr_nxt[w_g_lat] = age(w_ins, io_br_mispredict_mask, io_br_resolve_mask);
      if (io_flush)
         for (int k = 0; k < MAX_LAT; k++)
            w_sr_nxt[k] = '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < MAX_LAT; k++)
            r_sr[k] <= '0;
      end else begin
         r_sr <= w_sr_nxt;
      end
   end

`ifdef RR_ARB_EN
   logic [PTR_W-1:0] r_rr_ptr;
   logic [PTR_W-1:0] w_gidx;

   always_comb begin
      w_gidx = '0;
      for (int i = 0; i < NUM_SLOTS; i++)
         if (io_grant[i]) w_gidx = PTR_W'(i);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_rr_ptr <= '0;
      else if (io_iss_valid)
         r_rr_ptr <= (w_gidx == PTR_W'(NUM_SLOTS-1)) ? '0 : w_gidx + 1'b1;
   end

   assign w_ptr = r_rr_ptr;
`else
   assign w_ptr = '0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_p1_valid <= 1'b0;
         r_p1_pdst  <= '0;
      end else begin
         r_p1_valid <= io_ext_wakeup_valid & ~io_flush;
         r_p1_pdst  <= io_ext_wakeup_pdst;
      end
   end

   assign io_wakeup_ports_0_valid     = r_sr[0].valid;
   assign io_wakeup_ports_0_bits_pdst = r_sr[0].pdst;
   assign io_wakeup_ports_1_valid     = r_p1_valid;
   assign io_wakeup_ports_1_bits_pdst = r_p1_pdst;

endmodule
`default_nettype wire

// File: tb/tb_issue_select_wakeup.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_issue_select_wakeup : directed and random checks against a due-cycle model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_issue_select_wakeup;

   localparam int N  = 8;
   localparam int PW = 7;
   localparam int BW = 12;
   localparam int ML = 4;
   localparam int LW = 2;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    io_request, io_slot_ldst_val, io_grant;
   logic [N*PW-1:0] io_slot_pdst;
   logic [N*LW-1:0] io_slot_lat;
   logic [N*BW-1:0] io_slot_br_mask;
   logic            io_stall, io_flush, io_iss_valid, io_ext_wakeup_valid;
   logic [PW-1:0]   io_iss_pdst, io_ext_wakeup_pdst;
   logic [BW-1:0]   io_br_mispredict_mask, io_br_resolve_mask;
   logic            p0v, p1v;
   logic [PW-1:0]   p0p, p1p;

   always #5 clk = ~clk;

   issue_select_wakeup #(.NUM_SLOTS(N)) dut (
      .clk                         (clk),
      .reset                       (reset),
      .io_request                  (io_request),
      .io_slot_pdst                (io_slot_pdst),
      .io_slot_ldst_val            (io_slot_ldst_val),
      .io_slot_lat                 (io_slot_lat),
      .io_slot_br_mask             (io_slot_br_mask),
      .io_stall                    (io_stall),
      .io_grant                    (io_grant),
      .io_iss_valid                (io_iss_valid),
      .io_iss_pdst                 (io_iss_pdst),
      .io_br_mispredict_mask       (io_br_mispredict_mask),
      .io_br_resolve_mask          (io_br_resolve_mask),
      .io_flush                    (io_flush),
      .io_ext_wakeup_valid         (io_ext_wakeup_valid),
      .io_ext_wakeup_pdst          (io_ext_wakeup_pdst),
      .io_wakeup_ports_0_valid     (p0v),
      .io_wakeup_ports_0_bits_pdst (p0p),
      .io_wakeup_ports_1_valid     (p1v),
      .io_wakeup_ports_1_bits_pdst (p1p)
   );

   // Model: each in-flight wakeup is a record of the cycle it must appear on port 0.
   typedef struct {
      int            due;
      logic [PW-1:0] pdst;
      logic [BW-1:0] mask;
   } rec_t;

   rec_t          q[$];
   int            total = 0;
   int            bad   = 0;
   int            cyc   = 0;
   int            rr    = 0;
   logic          e1v   = 1'b0;
   logic [PW-1:0] e1p   = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s cycle=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic clr();
      io_request = '0; io_slot_ldst_val = '0; io_slot_pdst = '0;
      io_slot_lat = '0; io_slot_br_mask = '0; io_stall = 1'b0; io_flush = 1'b0;
      io_br_mispredict_mask = '0; io_br_resolve_mask = '0;
      io_ext_wakeup_valid = 1'b0; io_ext_wakeup_pdst = '0;
   endtask

   task automatic set_slot(input int i, input logic [PW-1:0] p, input logic ld,
                           input logic [LW-1:0] lat, input logic [BW-1:0] br);
      io_request[i]             = 1'b1;
      io_slot_pdst[i*PW +: PW]  = p;
      io_slot_ldst_val[i]       = ld;
      io_slot_lat[i*LW +: LW]   = lat;
      io_slot_br_mask[i*BW +: BW] = br;
   endtask

   task automatic model_reset();
      q.delete();
      rr  = 0;
      e1v = 1'b0;
      e1p = '0;
   endtask

   // Check all outputs for the current cycle, then advance the model and the clock.
   task automatic run_cycle();
      logic [N-1:0]  elig, eg;
      logic          e0v;
      logic [PW-1:0] e0p, eip;
      int            gi, lg, lv;
      rec_t          nq[$];
      rec_t          r;
      #2;
      e0v = 1'b0; e0p = '0;
      foreach (q[j]) if (q[j].due == cyc) begin e0v = 1'b1; e0p = q[j].pdst; end
      elig = '0;
      for (int i = 0; i < N; i++) begin
         elig[i] = io_request[i] && !io_stall && !io_flush;
         lv = int'(io_slot_lat[i*LW +: LW]) + 1;
         if (io_slot_ldst_val[i] && lv < ML)
            foreach (q[j]) if (q[j].due == cyc + lv) elig[i] = 1'b0;
      end
      gi = -1;
`ifdef RR_ARB_EN
      for (int off = 0; off < N; off++)
         if (gi < 0 && elig[(rr + off) % N]) gi = (rr + off) % N;
`else
      for (int i = 0; i < N; i++)
         if (gi < 0 && elig[i]) gi = i;
`endif
      eg = '0; eip = '0;
      if (gi >= 0) begin eg[gi] = 1'b1; eip = io_slot_pdst[gi*PW +: PW]; end
      chk("grant",     32'(io_grant),     32'(eg));
      chk("iss_valid", 32'(io_iss_valid), 32'(gi >= 0));
      chk("iss_pdst",  32'(io_iss_pdst),  32'(eip));
      chk("p0_valid",  32'(p0v),          32'(e0v));
      chk("p0_pdst",   32'(p0p),          32'(e0p));
      chk("p1_valid",  32'(p1v),          32'(e1v));
      chk("p1_pdst",   32'(p1v ? p1p : 7'd0), 32'(e1v ? e1p : 7'd0));
      foreach (q[j]) begin
         if (q[j].due > cyc && !io_flush && (q[j].mask & io_br_mispredict_mask) == '0) begin
            r = q[j];
            r.mask = r.mask & ~io_br_resolve_mask;
            nq.push_back(r);
         end
      end
      if (gi >= 0 && io_slot_ldst_val[gi] &&
          (io_slot_br_mask[gi*BW +: BW] & io_br_mispredict_mask) == '0) begin
         lg     = int'(io_slot_lat[gi*LW +: LW]) + 1;
         r.due  = cyc + lg;
         r.pdst = io_slot_pdst[gi*PW +: PW];
         r.mask = io_slot_br_mask[gi*BW +: BW] & ~io_br_resolve_mask;
         nq.push_back(r);
      end
      q = nq;
      if (gi >= 0) rr = (gi + 1) % N;
      e1v = io_ext_wakeup_valid && !io_flush;
      e1p = io_ext_wakeup_pdst;
      @(posedge clk); #1;
      cyc++;
   endtask

   initial begin
      reset = 1'b1;
      clr();
      model_reset();
      #1;
      chk("rst_p0_valid", 32'(p0v), 0);
      chk("rst_p0_pdst",  32'(p0p), 0);
      chk("rst_p1_valid", 32'(p1v), 0);
      chk("rst_p1_pdst",  32'(p1p), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      run_cycle();

      // Slot 3, pdst 0x2A, L=3: grant now, wakeup exactly three cycles later.
      clr(); set_slot(3, 7'h2A, 1'b1, 2'd2, '0);
      #1 chk("t2_grant", 32'(io_grant), 32'h08);
      run_cycle();
      clr(); run_cycle(); run_cycle();
      #1 chk("t2_p0_valid", 32'(p0v), 1);
      chk("t2_p0_pdst", 32'(p0p), 32'h2A);
      run_cycle(); run_cycle();

      // Collision: L=3 at t, then an L=2 slot is blocked at t+1, granted at t+2.
      clr(); set_slot(3, 7'h2A, 1'b1, 2'd2, '0);
      run_cycle();
      clr(); set_slot(5, 7'h15, 1'b1, 2'd1, '0);
      #1 chk("t3_blocked", 32'(io_grant), 0);
      run_cycle();
      #1 chk("t3_grant", 32'(io_grant), 32'h20);
      run_cycle();
      clr(); run_cycle();
      #1 chk("t3_p0_pdst", 32'(p0p), 32'h15);
      run_cycle(); run_cycle();

      // Two requesters 0x81 in consecutive cycles.
      clr(); set_slot(0, 7'h01, 1'b0, 2'd3, '0); set_slot(7, 7'h07, 1'b0, 2'd3, '0);
      for (int n = 0; n < 3; n++) begin
`ifndef RR_ARB_EN
         #1 chk("t4_fixed", 32'(io_grant), 32'h01);
`endif
         run_cycle();
      end

      // Branch kill / resolve / both, on a wakeup four cycles out.
      for (int mode = 0; mode < 3; mode++) begin
         clr(); set_slot(1, 7'h33 + 7'(mode), 1'b1, 2'd3, 12'h004);
         run_cycle();
         clr(); run_cycle();
         clr();
         if (mode != 1) io_br_mispredict_mask = 12'h004;
         if (mode != 0) io_br_resolve_mask    = 12'h004;
         run_cycle();
         clr();
         if (mode == 1) io_br_mispredict_mask = 12'h004;
         run_cycle();
         clr();
         #1 chk("t5_p0_valid", 32'(p0v), 32'(mode == 1));
         run_cycle();
      end

      // External wakeup retiming, and flush suppressing it along with in-flight entries.
      clr(); io_ext_wakeup_valid = 1'b1; io_ext_wakeup_pdst = 7'h11;
      set_slot(2, 7'h22, 1'b1, 2'd1, '0);
      run_cycle();
      clr();
      #1 chk("t6_p1_valid", 32'(p1v), 1);
      chk("t6_p1_pdst", 32'(p1p), 32'h11);
      io_ext_wakeup_valid = 1'b1; io_ext_wakeup_pdst = 7'h12; io_flush = 1'b1;
      set_slot(4, 7'h44, 1'b1, 2'd0, '0);
      #1 chk("t6_flush_grant", 32'(io_grant), 0);
      run_cycle();
      clr();
      #1 chk("t6_flush_p1", 32'(p1v), 0);
      chk("t6_flush_p0", 32'(p0v), 0);
      run_cycle(); run_cycle();

      // Random traffic.
      for (int n = 0; n < 400; n++) begin
         clr();
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 99) < 40)
               set_slot(i, 7'($urandom), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                        12'(1 << $urandom_range(0, 11)) | 12'(1 << $urandom_range(0, 11)));
         io_stall = ($urandom_range(0, 99) < 8);
         io_flush = ($urandom_range(0, 99) < 3);
         if ($urandom_range(0, 99) < 15) io_br_mispredict_mask = 12'(1 << $urandom_range(0, 11));
         if ($urandom_range(0, 99) < 25) io_br_resolve_mask    = 12'(1 << $urandom_range(0, 11));
         io_ext_wakeup_valid = 1'($urandom_range(0, 1));
         io_ext_wakeup_pdst  = 7'($urandom);
         run_cycle();
      end

      // Reset mid-stream with wakeups in flight.
      clr(); set_slot(6, 7'h5A, 1'b1, 2'd3, '0);
      io_ext_wakeup_valid = 1'b1; io_ext_wakeup_pdst = 7'h3C;
      run_cycle();
      clr(); set_slot(2, 7'h1B, 1'b1, 2'd1, '0);
      run_cycle();
      clr();
      reset = 1'b1;
      #1;
      chk("mrst_p0_valid", 32'(p0v), 0);
      chk("mrst_p0_pdst",  32'(p0p), 0);
      chk("mrst_p1_valid", 32'(p1v), 0);
      chk("mrst_p1_pdst",  32'(p1p), 0);
      chk("mrst_grant",    32'(io_grant), 0);
      model_reset();
      @(posedge clk); #1;
      reset = 1'b0;
      cyc++;
      for (int n = 0; n < 6; n++) run_cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
